// File: rtl/pll_domain_seq.sv
// pll_domain_seq: gate/reset/reprogram/relock sequencer for one PLL clock domain.
// Define PLL_SEQ_TIMEOUT_EN to add the WAIT_LOCK timeout counter and sticky err_o.
module pll_domain_seq #(
    parameter int REF_DIV_BW   = 4,
    parameter int FB_DIV_BW    = 12,
    parameter int INIT_REF_DIV = 1,
    parameter int INIT_FB_DIV  = 1,
    parameter int GATE_CYCLES  = 4,
    parameter int RST_HOLD     = 8,
    parameter int LOCK_STABLE  = 4,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [REF_DIV_BW-1:0] req_ref_div_i,
    input  logic [FB_DIV_BW-1:0]  req_fb_div_i,
    output logic [REF_DIV_BW-1:0] pll_ref_div_o,
    output logic [FB_DIV_BW-1:0]  pll_fb_div_o,
    input  logic                  pll_locked_i,
    output logic                  dom_clk_en_o,
    output logic                  dom_arst_n_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);
    localparam int CMAX = (GATE_CYCLES > RST_HOLD) ? GATE_CYCLES : RST_HOLD;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int SW   = $clog2(LOCK_STABLE + 1);

    typedef enum logic [2:0] {IDLE, ASSERT_RST, GATE, PROGRAM, WAIT_LOCK, UNGATE, RELEASE} state_t;

    state_t                state, state_nx;
    logic [1:0]            sync;
    logic [CW-1:0]         cnt, cnt_inc;
    logic [SW-1:0]         stable, stable_inc, stable_nx;
    logic [REF_DIV_BW-1:0] ref_sh, ref_nx;
    logic [FB_DIV_BW-1:0]  fb_sh, fb_nx;
    logic                  lock_s, accept, lock_ok, tmo_hit, clk_en_nx, arst_n_nx;

    assign lock_s     = sync[1];
    assign accept     = req_valid_i && req_ready_o;
    assign cnt_inc    = (cnt == CW'(CMAX)) ? cnt : cnt + 1'b1;
    assign stable_inc = (stable == SW'(LOCK_STABLE)) ? stable : stable + 1'b1;
    assign stable_nx  = lock_s ? stable_inc : '0;
    assign lock_ok    = stable_nx == SW'(LOCK_STABLE);

`ifdef PLL_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    logic [TW-1:0] tmo, tmo_inc;
    assign tmo_inc = (tmo == TW'(LOCK_TIMEOUT)) ? tmo : tmo + 1'b1;
    assign tmo_hit = tmo_inc == TW'(LOCK_TIMEOUT);
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            tmo   <= '0;
            err_o <= 1'b0;
        end else begin
            tmo   <= (state == PROGRAM) ? '0 : (state == WAIT_LOCK) ? tmo_inc : tmo;
            err_o <= accept ? 1'b0 : (state == WAIT_LOCK && state_nx == IDLE) ? 1'b1 : err_o;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) state <= WAIT_LOCK;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       state_nx = accept ? ASSERT_RST : IDLE;
            ASSERT_RST: state_nx = GATE;
            GATE:       state_nx = (cnt_inc == CW'(GATE_CYCLES)) ? PROGRAM : GATE;
            PROGRAM:    state_nx = WAIT_LOCK;
            WAIT_LOCK:  state_nx = lock_ok ? UNGATE : tmo_hit ? IDLE : WAIT_LOCK;
            UNGATE:     state_nx = (cnt_inc == CW'(RST_HOLD)) ? RELEASE : UNGATE;
            RELEASE:    state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    always_comb begin
        ref_nx    = (state == PROGRAM) ? ref_sh : pll_ref_div_o;
        fb_nx     = (state == PROGRAM) ? fb_sh : pll_fb_div_o;
        clk_en_nx = (state == GATE) ? 1'b0 : (state == UNGATE) ? 1'b1 : dom_clk_en_o;
        arst_n_nx = (state == ASSERT_RST) ? 1'b0 : (state == RELEASE) ? 1'b1 : dom_arst_n_o;
    end

    // Synchroniser restarts in PROGRAM so a lock held over from the old dividers is not trusted.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            sync          <= '0;
            cnt           <= '0;
            stable        <= '0;
            ref_sh        <= REF_DIV_BW'(INIT_REF_DIV);
            fb_sh         <= FB_DIV_BW'(INIT_FB_DIV);
            pll_ref_div_o <= REF_DIV_BW'(INIT_REF_DIV);
            pll_fb_div_o  <= FB_DIV_BW'(INIT_FB_DIV);
            dom_clk_en_o  <= 1'b0;
            dom_arst_n_o  <= 1'b0;
            req_ready_o   <= 1'b0;
            busy_o        <= 1'b1;
            done_o        <= 1'b0;
        end else begin
            sync          <= (state == PROGRAM) ? 2'b00 : {sync[0], pll_locked_i};
            cnt           <= (state != state_nx) ? '0 : cnt_inc;
            stable        <= (state == PROGRAM) ? '0 : (state == WAIT_LOCK) ? stable_nx : stable;
            ref_sh        <= accept ? req_ref_div_i : ref_sh;
            fb_sh         <= accept ? req_fb_div_i : fb_sh;
            pll_ref_div_o <= ref_nx;
            pll_fb_div_o  <= fb_nx;
            dom_clk_en_o  <= clk_en_nx;
            dom_arst_n_o  <= arst_n_nx;
            req_ready_o   <= state_nx == IDLE;
            busy_o        <= state_nx != IDLE;
            done_o        <= state == RELEASE;
        end
    end
endmodule

// File: doc/pll_domain_seq.md
# pll_domain_seq

Sequencer that owns one PLL-driven clock domain (core 0, core 1 or system link) and performs safe frequency changes on request. It holds the domain in reset and gates its clock, reprograms the PLL dividers, waits for a stable lock, then ungates the clock and releases reset. It sits between the SoC control register file, which raises requests, and the PLL plus domain clock-enable/reset outputs. One instance is used per PLL.

## Interface
- `REF_DIV_BW`, 4: PLL reference divider width.
- `FB_DIV_BW`, 12: PLL feedback divider width.
- `INIT_REF_DIV`, 1: reference divider value loaded at reset.
- `INIT_FB_DIV`, 1: feedback divider value loaded at reset.
- `GATE_CYCLES`, 4: cycles the clock stays gated before the dividers change (≥1).
- `RST_HOLD`, 8: cycles reset stays asserted after the clock is ungated (≥1).
- `LOCK_STABLE`, 4: consecutive synchronised lock samples required (≥1).
- `LOCK_TIMEOUT`, 1024: maximum WAIT_LOCK cycles (only with `PLL_SEQ_TIMEOUT_EN`).

Ports:
- `clk_i` in 1: reference clock; all state is clocked on the rising edge.
- `arst_i` in 1: asynchronous reset, active-high.
- `req_valid_i` in 1: frequency-change request.
- `req_ready_o` out 1: request accepted when `req_valid_i && req_ready_o`.
- `req_ref_div_i` in REF_DIV_BW: new reference divider.
- `req_fb_div_i` in FB_DIV_BW: new feedback divider.
- `pll_ref_div_o` out REF_DIV_BW: divider driven to the PLL.
- `pll_fb_div_o` out FB_DIV_BW: divider driven to the PLL.
- `pll_locked_i` in 1: PLL lock, asynchronous to `clk_i`.
- `dom_clk_en_o` out 1: domain clock enable.
- `dom_arst_n_o` out 1: domain reset, active-low.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle pulse when a sequence completes successfully.
- `err_o` out 1: sticky lock-timeout flag.

## Operation
- `pll_locked_i` passes through a 2-flop synchroniser to give `lock_s`.
- States and behaviour:
  - IDLE: `req_ready_o`=1. On handshake, latch both dividers into shadow registers, clear `err_o`, go to ASSERT_RST.
  - ASSERT_RST: `dom_arst_n_o`←0. Go to GATE next cycle.
  - GATE: `dom_clk_en_o`←0. Count `GATE_CYCLES` cycles, then go to PROGRAM.
  - PROGRAM: the PLL divider outputs load the shadow values. Counters clear. Go to WAIT_LOCK next cycle.
  - WAIT_LOCK: the stable counter increments while `lock_s`=1 and clears to 0 when `lock_s`=0. When it reaches `LOCK_STABLE`, go to UNGATE. The timeout counter increments every cycle; on reaching `LOCK_TIMEOUT`, set `err_o` and go to IDLE.
  - UNGATE: `dom_clk_en_o`←1 while reset stays asserted. Count `RST_HOLD` cycles, then go to RELEASE.
  - RELEASE: `dom_arst_n_o`←1, `done_o`=1 for this cycle, go to IDLE.
- After a timeout the domain stays gated and in reset, and the PLL keeps the failed dividers. A new request restarts the full sequence.
- Requests are not queued. `req_ready_o`=0 outside IDLE, so requests there are held off by the handshake.
- Divider outputs change only in PROGRAM and hold steady in every other state.
- Counters are sized to `$clog2(max+1)` and saturate; they never wrap.

## Timing
- Reset values: state=WAIT_LOCK (boot sequence), `pll_ref_div_o`=INIT_REF_DIV, `pll_fb_div_o`=INIT_FB_DIV, `dom_clk_en_o`=0, `dom_arst_n_o`=0, `req_ready_o`=0, `busy_o`=1, `done_o`=0, `err_o`=0, synchroniser=0. Leaving reset therefore performs the boot lock, ungate and release automatically.
- All outputs are registered.
- Minimum request-to-done latency = 1 + 1 + GATE_CYCLES + 1 + (2 sync + LOCK_STABLE) + RST_HOLD + 1 cycles. With defaults and an already-locked PLL this is 22 cycles.
- A lock drop in UNGATE or RELEASE is ignored; the sequence completes.
- If `arst_i` is asserted mid-sequence, the block returns immediately to the reset values and reboots with the INIT dividers.

## Configuration
- `PLL_SEQ_TIMEOUT_EN` defined: the timeout counter and `err_o` are present as described.
- `PLL_SEQ_TIMEOUT_EN` undefined: WAIT_LOCK waits indefinitely for lock, `err_o` is tied to 0, and `LOCK_TIMEOUT` is unused.

## Test plan
- Reset with PLL model locked at the INIT dividers → `dom_arst_n_o` rises 15 cycles after deassert (2 sync + LOCK_STABLE 4 + RST_HOLD 8 + 1), one `done_o` pulse, then `req_ready_o`=1.
- Request ref=2, fb=40 in IDLE → `dom_arst_n_o`=0 next cycle, `dom_clk_en_o`=0 for ≥4 cycles before `pll_fb_div_o`=40. After relock, `done_o` pulse; total 22 cycles when already locked.
- Lock toggles 1,1,0,1,1,1,1 in WAIT_LOCK → stable count restarts at the drop; UNGATE is entered only after 4 consecutive high samples.
- `PLL_SEQ_TIMEOUT_EN`, `LOCK_TIMEOUT`=16, lock held low → `err_o`=1 after 16 WAIT_LOCK cycles, domain stays gated and in reset, no `done_o`. A following valid request clears `err_o`.
- `req_valid_i` held high during a sequence with different dividers → no second accept until IDLE, and the in-flight shadow values stay unchanged.
- `arst_i` pulsed during GATE → outputs return to reset values asynchronously and the boot sequence reruns with the INIT dividers.
